// File: rtl/jtag_dma_controller_if.sv
// Bus-side handshake of the JTAG DMA controller.
//   master : the DMA controller (drives request, begin, transfer parameters, write beats)
//   slave  : the bus / arbiter (drives grant, read beats, stall, end of transfer, error)
`timescale 1ns/1ps
interface jtag_dma_controller_if;
    logic        bus_request;
    logic        bus_grant;
    logic        bus_begin_transaction;
    logic        bus_read_n_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_enable;
    logic [7:0]  bus_burst_size;
    logic [31:0] bus_data_out;
    logic        bus_data_valid;
    logic [31:0] bus_data_in;
    logic        bus_data_in_valid;
    logic        bus_busy;
    logic        bus_end_transaction;
    logic        bus_error;

    modport master (
        output bus_request, bus_begin_transaction, bus_read_n_write,
               bus_address, bus_byte_enable, bus_burst_size,
               bus_data_out, bus_data_valid,
        input  bus_grant, bus_data_in, bus_data_in_valid,
               bus_busy, bus_end_transaction, bus_error
    );

    modport slave (
        input  bus_request, bus_begin_transaction, bus_read_n_write,
               bus_address, bus_byte_enable, bus_burst_size,
               bus_data_out, bus_data_valid,
        output bus_grant, bus_data_in, bus_data_in_valid,
               bus_busy, bus_end_transaction, bus_error
    );
endinterface

// File: rtl/jtag_dma_controller.sv
// JTAG DMA controller: moves burst_size+1 words between a ping-pong buffer
// and a burst bus, in either direction.
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   cmd_write / cmd_read              one-cycle launch pulses (write wins if both)
//   cmd_address/byte_enable/burst_size transfer parameters sampled with the pulse
//   switch_ready / busy / error       idle flag, transfer-running flag, sticky abort flag
//   pp_address/writeEnable/dataIn     controller-side buffer port (read data pp_dataOut, 1-cycle latency)
//   bus                               bus handshake (master modport)
`timescale 1ns/1ps
module jtag_dma_controller #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_write,
    input  logic        cmd_read,
    input  logic [31:0] cmd_address,
    input  logic [3:0]  cmd_byte_enable,
    input  logic [7:0]  cmd_burst_size,
    output logic        switch_ready,
    output logic        busy,
    output logic        error,
    output logic [8:0]  pp_address,
    output logic        pp_writeEnable,
    output logic [31:0] pp_dataIn,
    input  logic [31:0] pp_dataOut,
    jtag_dma_controller_if.master bus
);
    localparam int TW = $clog2(BUS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, REQUEST, BEGIN, PREFETCH, WRITE_DATA, READ_DATA, WAIT_END, DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   addr_reg;
    logic [3:0]    be_reg;
    logic [7:0]    size_reg;
    logic          dir_read_reg;
    logic [7:0]    index_reg;
    logic [TW-1:0] timeout_reg;
    logic          error_reg;
    logic          switch_ready_reg, busy_reg;
    logic          bus_request_reg, bus_begin_reg, bus_data_valid_reg;
    logic [31:0]   bus_address_reg;
    logic [3:0]    bus_be_reg;
    logic [7:0]    bus_size_reg;

    logic       launch, beat, last_beat, counting, timed_out, bus_abort;
    logic [7:0] fetch_index;

    assign launch    = cmd_write | cmd_read;
    assign beat      = ((state_reg == WRITE_DATA) && !bus.bus_busy) ||
                       ((state_reg == READ_DATA) && bus.bus_data_in_valid);
    assign last_beat = beat && (index_reg == size_reg);
    assign counting  = (state_reg == WRITE_DATA) || (state_reg == READ_DATA) ||
                       (state_reg == WAIT_END);
    // The compare is against BUS_TIMEOUT-1 so the abort takes effect after
    // exactly BUS_TIMEOUT consecutive idle cycles.
    assign timed_out = counting && !beat && (timeout_reg == TW'(BUS_TIMEOUT - 1));
    assign bus_abort = bus.bus_error && (state_reg != IDLE) && (state_reg != DONE);

    always_comb begin
        state_next = state_reg;
        if (bus_abort) begin
            state_next = DONE;
        end else begin
            case (state_reg)
                IDLE:       if (launch) state_next = REQUEST;
                REQUEST:    if (bus.bus_grant) state_next = BEGIN;
                BEGIN:      state_next = dir_read_reg ? READ_DATA : PREFETCH;
                PREFETCH:   state_next = WRITE_DATA;
                WRITE_DATA, READ_DATA: begin
                    if (bus.bus_end_transaction) state_next = DONE;
                    else if (last_beat)          state_next = WAIT_END;
                    else if (timed_out)          state_next = DONE;
                end
                WAIT_END:   if (bus.bus_end_transaction || timed_out) state_next = DONE;
                DONE:       state_next = IDLE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= IDLE;
            addr_reg           <= '0;
            be_reg             <= '0;
            size_reg           <= '0;
            dir_read_reg       <= 1'b0;
            index_reg          <= '0;
            timeout_reg        <= '0;
            error_reg          <= 1'b0;
            switch_ready_reg   <= 1'b1;
            busy_reg           <= 1'b0;
            bus_request_reg    <= 1'b0;
            bus_begin_reg      <= 1'b0;
            bus_data_valid_reg <= 1'b0;
            bus_address_reg    <= '0;
            bus_be_reg         <= '0;
            bus_size_reg       <= '0;
        end else begin
            state_reg          <= state_next;
            switch_ready_reg   <= (state_next == IDLE);
            busy_reg           <= (state_next != IDLE);
            bus_request_reg    <= (state_next != IDLE) && (state_next != DONE);
            bus_begin_reg      <= (state_next == BEGIN);
            bus_data_valid_reg <= (state_next == WRITE_DATA);
            bus_address_reg    <= (state_next == BEGIN) ? addr_reg : '0;
            bus_be_reg         <= (state_next == BEGIN) ? be_reg : '0;
            bus_size_reg       <= (state_next == BEGIN) ? size_reg : '0;

            if ((state_next != state_reg) || beat)
                timeout_reg <= '0;
            else if (counting)
                timeout_reg <= timeout_reg + 1'b1;

            if ((state_reg == IDLE) && launch) begin
                addr_reg     <= cmd_address;
                be_reg       <= cmd_byte_enable;
                size_reg     <= cmd_burst_size;
                dir_read_reg <= !cmd_write;
                index_reg    <= '0;
                error_reg    <= 1'b0;
            end
            if (beat)
                index_reg <= index_reg + 8'd1;
            if (state_reg == DONE) begin
                index_reg    <= '0;
                dir_read_reg <= 1'b0;
            end
            if (((state_reg != IDLE) && bus.bus_error) || timed_out)
                error_reg <= 1'b1;
        end
    end

    // On an accepted write beat the next word's address is presented at once,
    // so the buffer's one-cycle latency lines the new word up for the next
    // beat; during a stall the same address is re-read and the data holds.
    assign fetch_index    = ((state_reg == WRITE_DATA) && !bus.bus_busy) ?
                            index_reg + 8'd1 : index_reg;
    assign pp_address     = {1'b0, fetch_index};
    assign pp_writeEnable = (state_reg == READ_DATA) && bus.bus_data_in_valid && !reset;
    assign pp_dataIn      = (state_reg == READ_DATA) ? bus.bus_data_in : '0;

    assign switch_ready              = switch_ready_reg;
    assign busy                      = busy_reg;
    assign error                     = error_reg;
    assign bus.bus_request           = bus_request_reg;
    assign bus.bus_begin_transaction = bus_begin_reg;
    assign bus.bus_read_n_write      = dir_read_reg;
    assign bus.bus_address           = bus_address_reg;
    assign bus.bus_byte_enable       = bus_be_reg;
    assign bus.bus_burst_size        = bus_size_reg;
    assign bus.bus_data_valid        = bus_data_valid_reg;
    assign bus.bus_data_out          = (state_reg == WRITE_DATA) ? pp_dataOut : '0;
endmodule

// File: tb/tb_jtag_dma_controller.sv
`timescale 1ns/1ps
module tb_jtag_dma_controller;
    localparam int TB_TIMEOUT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_write, cmd_read;
    logic [31:0] cmd_address;
    logic [3:0]  cmd_byte_enable;
    logic [7:0]  cmd_burst_size;
    logic        switch_ready, busy, error;
    logic [8:0]  pp_address;
    logic        pp_writeEnable;
    logic [31:0] pp_dataIn, pp_dataOut;

    jtag_dma_controller_if bus ();

    jtag_dma_controller #(.BUS_TIMEOUT(TB_TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_address(cmd_address), .cmd_byte_enable(cmd_byte_enable),
        .cmd_burst_size(cmd_burst_size),
        .switch_ready(switch_ready), .busy(busy), .error(error),
        .pp_address(pp_address), .pp_writeEnable(pp_writeEnable),
        .pp_dataIn(pp_dataIn), .pp_dataOut(pp_dataOut),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Ping-pong buffer model: one-cycle read latency, plus a bench load port.
    logic [31:0] buf_mem [512];
    logic        tb_load;
    logic [8:0]  tb_addr;
    logic [31:0] tb_data;
    always @(posedge clock) begin
        pp_dataOut <= buf_mem[pp_address];
        if (tb_load)             buf_mem[tb_addr] <= tb_data;
        else if (pp_writeEnable) buf_mem[pp_address] <= pp_dataIn;
    end

    int checks = 0;
    int errors = 0;

    // Scoreboard state: expected command, expected write beats, expected buffer writes.
    logic        mon_en = 1'b0;
    logic        exp_begin_pending = 1'b0;
    logic        exp_rnw;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [7:0]  exp_size;
    logic [31:0] exp_wq[$];
    logic [40:0] exp_rq[$];
    logic [31:0] beat_log[$];
    int          begin_cnt = 0;
    int          wr_count = 0;
    logic [31:0] t1_exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Compare process: every cycle, DUT outputs against the scoreboard.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic [40:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clock);
            if (mon_en && !reset) begin
                chk("ready_is_not_busy", switch_ready, !busy);
                chk("pp_addr_bit8", pp_address[8], 1'b0);
                if (bus.bus_begin_transaction) begin
                    chk("begin_expected", exp_begin_pending, 1'b1);
                    chk("begin_fields",
                        {bus.bus_read_n_write, bus.bus_address, bus.bus_byte_enable, bus.bus_burst_size},
                        {exp_rnw, exp_addr, exp_be, exp_size});
                    exp_begin_pending = 1'b0;
                    begin_cnt++;
                end else begin
                    chk("bus_params_zero",
                        {bus.bus_address, bus.bus_byte_enable, bus.bus_burst_size}, 64'd0);
                end
                if (prev_stall && bus.bus_data_valid)
                    chk("stall_hold", bus.bus_data_out, prev_data);
                if (bus.bus_data_valid && !bus.bus_busy) begin
                    chk("beat_expected", exp_wq.size() != 0, 1'b1);
                    if (exp_wq.size() != 0) chk("beat_data", bus.bus_data_out, exp_wq.pop_front());
                    beat_log.push_back(bus.bus_data_out);
                end
                prev_stall = bus.bus_data_valid && bus.bus_busy;
                prev_data  = bus.bus_data_out;
                if (pp_writeEnable) begin
                    wr_count++;
                    chk("bufwrite_expected", exp_rq.size() != 0, 1'b1);
                    if (exp_rq.size() != 0) begin
                        e = exp_rq.pop_front();
                        chk("bufwrite_addr_data", {pp_address, pp_dataIn}, e);
                    end
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic load_word(input int a, input logic [31:0] d);
        tb_load = 1'b1; tb_addr = a[8:0]; tb_data = d;
        tick();
        tb_load = 1'b0;
    endtask

    task automatic issue(input logic w, input logic r, input logic [31:0] a,
                         input logic [3:0] be, input logic [7:0] sz);
        exp_addr = a; exp_be = be; exp_size = sz; exp_rnw = !w;
        exp_begin_pending = 1'b1;
        begin_cnt = 0; wr_count = 0;
        beat_log.delete();
        if (w) for (int i = 0; i <= int'(sz); i++) exp_wq.push_back(buf_mem[i]);
        cmd_write = w; cmd_read = r; cmd_address = a; cmd_byte_enable = be; cmd_burst_size = sz;
        tick();
        cmd_write = 1'b0; cmd_read = 1'b0; cmd_address = '0; cmd_byte_enable = '0; cmd_burst_size = '0;
    endtask

    task automatic grant_phase(input int delay);
        int k;
        k = 0;
        while (!bus.bus_request && k < 50) begin tick(); k++; end
        chk("request_seen", bus.bus_request, 1'b1);
        repeat (delay) tick();
        bus.bus_grant = 1'b1;
        k = 0;
        while (!bus.bus_begin_transaction && k < 50) begin tick(); k++; end
        chk("begin_seen", bus.bus_begin_transaction, 1'b1);
        bus.bus_grant = 1'b0;
    endtask

    task automatic write_data(input int n, input int stall_beat, input int stall_len);
        int b, stalled, budget;
        b = 0; stalled = 0; budget = 100;
        while (b < n && budget > 0) begin
            if (bus.bus_data_valid) begin
                if (b == stall_beat && stalled < stall_len) begin
                    bus.bus_busy = 1'b1; stalled++;
                end else begin
                    bus.bus_busy = 1'b0; b++;
                end
            end else begin
                bus.bus_busy = 1'b0;
            end
            tick();
            budget--;
        end
        bus.bus_busy = 1'b0;
        chk("write_beats_done", b, n);
    endtask

    task automatic read_data(input int n, input logic [31:0] base);
        logic [8:0] idx;
        for (int k = 0; k < n; k++) begin
            tick();
            idx = k[8:0];
            bus.bus_data_in_valid = 1'b1;
            bus.bus_data_in = base + k;
            exp_rq.push_back({idx, base + k});
        end
        tick();
        bus.bus_data_in_valid = 1'b0;
        bus.bus_data_in = '0;
    endtask

    task automatic end_phase();
        bus.bus_end_transaction = 1'b1;
        tick();
        bus.bus_end_transaction = 1'b0;
        chk("done_still_busy", busy, 1'b1);
        chk("done_request_dropped", bus.bus_request, 1'b0);
        tick();
        chk("idle_after_done", switch_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        cmd_write = 1'b0; cmd_read = 1'b0;
        cmd_address = '0; cmd_byte_enable = '0; cmd_burst_size = '0;
        tb_load = 1'b0; tb_addr = '0; tb_data = '0;
        bus.bus_grant = 1'b0; bus.bus_data_in = '0; bus.bus_data_in_valid = 1'b0;
        bus.bus_busy = 1'b0; bus.bus_end_transaction = 1'b0; bus.bus_error = 1'b0;
        tick(); tick();
        chk("reset_switch_ready", switch_ready, 1'b1);
        chk("reset_outputs_zero",
            {busy, error, bus.bus_request, bus.bus_begin_transaction, bus.bus_data_valid,
             pp_writeEnable, bus.bus_read_n_write}, 64'd0);
        load_word(0, 32'h11); load_word(1, 32'h22); load_word(2, 32'h33); load_word(3, 32'h44);
        reset = 1'b0;
        tick();
        mon_en = 1'b1;

        // Write burst of 4 with a one-cycle stall on beat 1
        issue(1'b1, 1'b0, 32'h100, 4'hF, 8'd3);
        grant_phase(2);
        write_data(4, 1, 1);
        end_phase();
        chk("t1_begin_count", begin_cnt, 1);
        chk("t1_beat_count", beat_log.size(), 4);
        for (int i = 0; i < 4 && i < beat_log.size(); i++) chk("t1_beat_literal", beat_log[i], t1_exp[i]);
        chk("t1_error", error, 1'b0);
        $display("[tb] write burst addr 0x100 size 3: %0d beats", beat_log.size());

        // Single-word read
        issue(1'b0, 1'b1, 32'h80, 4'hF, 8'd0);
        chk("t2_not_ready_during", switch_ready, 1'b0);
        grant_phase(1);
        read_data(1, 32'hDEADBEEF);
        end_phase();
        chk("t2_buf0", buf_mem[0], 32'hDEADBEEF);
        chk("t2_write_count", wr_count, 1);
        chk("t2_error", error, 1'b0);
        $display("[tb] read size 0: %0d buffer writes", wr_count);

        // Simultaneous commands run the write; a read while busy is ignored
        issue(1'b1, 1'b1, 32'h200, 4'h3, 8'd1);
        fork
            begin
                grant_phase(0);
                write_data(2, -1, 0);
                end_phase();
            end
            begin
                repeat (3) tick();
                cmd_read = 1'b1;
                tick();
                cmd_read = 1'b0;
            end
        join
        repeat (4) tick();
        chk("t3_still_idle", switch_ready, 1'b1);
        chk("t3_begin_count", begin_cnt, 1);
        $display("[tb] simultaneous cmd: write of %0d beats, stray read ignored", beat_log.size());

        // Bus error during a read
        issue(1'b0, 1'b1, 32'h500, 4'hF, 8'd3);
        grant_phase(0);
        read_data(1, 32'h12345678);
        bus.bus_error = 1'b1;
        tick();
        bus.bus_error = 1'b0;
        chk("t4_error_set", error, 1'b1);
        chk("t4_done_busy", busy, 1'b1);
        chk("t4_request_dropped", bus.bus_request, 1'b0);
        tick();
        chk("t4_idle", switch_ready, 1'b1);
        chk("t4_error_sticky", error, 1'b1);
        chk("t4_no_pending_writes", exp_rq.size(), 0);
        $display("[tb] bus error abort: error=%0b", error);

        // Timeout with no beats
        issue(1'b0, 1'b1, 32'h600, 4'hF, 8'd2);
        chk("t5_error_cleared", error, 1'b0);
        grant_phase(0);
        repeat (TB_TIMEOUT) tick();
        chk("t5_no_error_yet", error, 1'b0);
        chk("t5_still_busy", busy, 1'b1);
        tick();
        chk("t5_timeout_error", error, 1'b1);
        chk("t5_request_dropped", bus.bus_request, 1'b0);
        tick();
        chk("t5_idle", switch_ready, 1'b1);
        $display("[tb] timeout abort after %0d idle cycles: error=%0b", TB_TIMEOUT, error);

        // Following command clears the error
        issue(1'b1, 1'b0, 32'h700, 4'h1, 8'd0);
        chk("t5b_error_cleared", error, 1'b0);
        grant_phase(1);
        write_data(1, -1, 0);
        end_phase();
        chk("t5b_error_clean", error, 1'b0);
        $display("[tb] write after abort: %0d beat, error=%0b", beat_log.size(), error);

        // Reset in the middle of a write, at beat 2
        issue(1'b1, 1'b0, 32'h300, 4'hF, 8'd3);
        grant_phase(0);
        write_data(2, -1, 0);
        reset = 1'b1;
        tick();
        chk("t6_idle", switch_ready, 1'b1);
        chk("t6_quiet", {busy, bus.bus_request, bus.bus_data_valid, bus.bus_begin_transaction}, 64'd0);
        reset = 1'b0;
        exp_wq.delete();
        exp_begin_pending = 1'b0;
        wr_count = 0;
        chk("t6_beats_before_reset", beat_log.size(), 2);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t6_no_request", bus.bus_request, 1'b0);
        end
        chk("t6_no_buffer_writes", wr_count, 0);
        chk("t6_no_new_beats", beat_log.size(), 2);
        $display("[tb] reset mid-write: controller idle, no further activity");

        // Full-size read: 256 words
        issue(1'b0, 1'b1, 32'h400, 4'hC, 8'd255);
        grant_phase(0);
        read_data(256, 32'hA5000000);
        end_phase();
        chk("t7_write_count", wr_count, 256);
        chk("t7_buf0", buf_mem[0], 32'hA5000000);
        chk("t7_buf255", buf_mem[255], 32'hA50000FF);
        chk("t7_buf256_untouched", buf_mem[256] === 32'hA5000000, 1'b0);
        chk("t7_error", error, 1'b0);
        $display("[tb] read size 255: %0d buffer writes", wr_count);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_dma_controller.md
JTAG_DMA_CONTROLLER -- requirements
Module: jtag_dma_controller

Interface
REQ-001 Parameter BUS_TIMEOUT, default 255, is the maximum number of idle cycles allowed between bus data beats before the transfer aborts.
REQ-002 clock  in  1  system clock; all logic SHALL be rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmd_write  in  1  one-cycle pulse that launches a buffer-to-bus burst write; already synchronised to clock.
REQ-005 cmd_read  in  1  one-cycle pulse that launches a bus-to-buffer burst read.
REQ-006 cmd_address / cmd_byte_enable / cmd_burst_size  in  32/4/8  transfer parameters, sampled with the command pulse.
REQ-007 switch_ready  out  1  high when the controller is IDLE, meaning the ping-pong buffer may be switched.
REQ-008 busy / error  out  1/1  busy is high while a transfer runs; error is sticky and set on an abort.
REQ-009 pp_address / pp_writeEnable / pp_dataIn  out  9/1/32  controller-side port of the ping-pong buffer.
REQ-010 pp_dataOut  in  32  buffer read data, valid one cycle after the address is applied.
REQ-011 bus_request  out  1  bus request; bus_grant  in  1  bus grant.
REQ-012 bus_begin_transaction / bus_read_n_write  out  1/1  begin pulse and direction (1 = read).
REQ-013 bus_address / bus_byte_enable / bus_burst_size  out  32/4/8  transfer parameters, valid only during the begin pulse and 0 otherwise.
REQ-014 bus_data_out / bus_data_valid  out  32/1  write data beat.
REQ-015 bus_data_in / bus_data_in_valid  in  32/1  read data beat.
REQ-016 bus_busy / bus_end_transaction / bus_error  in  1/1/1  slave stall, end of transfer, and error.

Function
REQ-017 The state machine SHALL have the states IDLE, REQUEST, BEGIN, PREFETCH, WRITE_DATA, READ_DATA, WAIT_END and DONE.
REQ-018 In IDLE, a cmd_write or cmd_read pulse SHALL latch address, byte enable, burst size and direction, clear error, and go to REQUEST on the next cycle.
REQ-019 Simultaneous cmd_write and cmd_read SHALL execute the write and ignore the read.
REQ-020 Commands received outside IDLE SHALL be ignored.
REQ-021 A transfer SHALL move exactly burst_size+1 words; burst_size=0 moves 1 word and burst_size=255 moves 256 words.
REQ-022 The buffer word index SHALL start at 0, count to burst_size, and drive pp_address = {1'b0, index}.
REQ-023 REQUEST SHALL hold bus_request high until bus_grant is sampled high, then go to BEGIN.
REQ-024 bus_request SHALL stay high from REQUEST until DONE.
REQ-025 BEGIN SHALL last exactly one cycle, with bus_begin_transaction=1 and the latched parameters on the bus.
REQ-026 After BEGIN, a write SHALL go to PREFETCH and a read SHALL go to READ_DATA.
REQ-027 PREFETCH SHALL drive pp_address=index for one cycle, then go to WRITE_DATA.
REQ-028 WRITE_DATA SHALL drive bus_data_valid=1 with bus_data_out=pp_dataOut.
REQ-029 In WRITE_DATA, a beat SHALL be accepted when bus_busy=0; on acceptance the index SHALL increment and the next word SHALL be prefetched.
REQ-030 In WRITE_DATA, while bus_busy=1 the data SHALL be held unchanged.
REQ-031 After the last accepted write beat, the controller SHALL go to WAIT_END.
REQ-032 READ_DATA SHALL write bus_data_in to the buffer (pp_writeEnable=1, pp_address=index) in the same cycle that bus_data_in_valid=1, then increment the index.
REQ-033 After the last read beat, the controller SHALL go to WAIT_END.
REQ-034 WAIT_END SHALL wait for bus_end_transaction, then go to DONE.
REQ-035 If bus_end_transaction arrives earlier, during a data phase, the controller SHALL go directly to DONE and SHALL NOT set error.
REQ-036 DONE SHALL last one cycle, drop bus_request, and return to IDLE.
REQ-037 pp_writeEnable SHALL be 1 only in READ_DATA on a valid beat.
REQ-038 bus_error=1 in any non-IDLE state SHALL set error and go to DONE on the next cycle.
REQ-039 A timeout counter SHALL reset on every beat and on every state change, and SHALL increment in WRITE_DATA, READ_DATA and WAIT_END.
REQ-040 When the timeout counter reaches BUS_TIMEOUT, the controller SHALL set error and go to DONE.
REQ-041 switch_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).

Reset
REQ-042 When reset=1, including mid-transfer, the controller SHALL enter IDLE on the next edge.
REQ-043 On reset, every output SHALL be 0 except switch_ready=1, and error, the index and the timeout counter SHALL be cleared.
REQ-044 A reset during a transfer SHALL drop bus_request immediately and SHALL write nothing further to the buffer.

Verification
REQ-045 Write: buffer words 0..3 = 0x11,0x22,0x33,0x44, cmd_write with address 0x100, byte enable 0xF, size 3, grant after 2 cycles, bus_busy=1 for 1 cycle on beat 1 -> exactly one begin pulse with address 0x100 and size 3; four beats 0x11..0x44 in order; beat 1 held during the stall; return to IDLE one cycle after end_transaction; error=0.
REQ-046 Read: cmd_read with size 0 and one read beat 0xDEADBEEF -> single buffer write at address 0 with 0xDEADBEEF; switch_ready=0 during the transfer and 1 afterwards.
REQ-047 Simultaneous cmd_write and cmd_read -> a write transfer (bus_read_n_write=0); a cmd_read sent while busy is ignored.
REQ-048 Error/timeout: bus_error pulse during READ_DATA -> error=1, then DONE, then IDLE; with BUS_TIMEOUT=8 and no beats -> error after 8 cycles; a following command clears error.
REQ-049 Reset mid-write at beat 2 -> the next cycle has IDLE, bus_request=0, bus_data_valid=0, switch_ready=1, and no later buffer or bus activity.
REQ-050 Size 255 read -> 256 buffer writes at addresses 0..255 with no index wrap into bit 8.
